// File: rtl/joint_pos_counter.sv
// Multi-channel saturating joint position counter with press/hold auto-repeat.
// Optional auto-repeat build: define JOINT_AUTOREPEAT_EN (otherwise one step per press).
module joint_pos_counter #(
  parameter int WIDTH    = 8,
  parameter int NCH      = 4,
  parameter int POS_MIN  = 0,
  parameter int POS_MAX  = 2**WIDTH-1,
  parameter int INIT_POS = 0,
  parameter int HOLD_DLY = 4,
  parameter int RPT_PER  = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NCH-1:0]                         cnt_up,
  input  logic [NCH-1:0]                         cnt_down,
  input  logic                                   load,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] load_ch,
  input  logic [WIDTH-1:0]                       load_val,
  output logic [NCH*WIDTH-1:0]                   pos,
  output logic [NCH-1:0]                         at_min,
  output logic [NCH-1:0]                         at_max,
  output logic [NCH-1:0]                         step_pulse
);

  localparam logic [WIDTH:0] PMIN = (WIDTH+1)'(POS_MIN);
  localparam logic [WIDTH:0] PMAX = (WIDTH+1)'(POS_MAX);

`ifdef JOINT_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  localparam int TMAX = (HOLD_DLY > RPT_PER) ? HOLD_DLY : RPT_PER;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  logic [TW-1:0] timer_q [NCH];
  logic [TW-1:0] ntimer  [NCH];
`else
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
  localparam int unused_cfg = HOLD_DLY + RPT_PER;
`endif

  state_t           state_q [NCH];
  state_t           nstate  [NCH];
  logic             dir_q   [NCH];  // 1 = up, 0 = down
  logic             ndir    [NCH];
  logic [WIDTH-1:0] pos_q   [NCH];
  logic [WIDTH-1:0] npos    [NCH];

  logic             req_up, req_dn, match, step, step_dir;
  logic [WIDTH:0]   ext, lv;

  always_comb begin
    req_up   = 1'b0;
    req_dn   = 1'b0;
    match    = 1'b0;
    step     = 1'b0;
    step_dir = 1'b0;
    ext      = '0;
    lv       = '0;
    for (int i = 0; i < NCH; i++) begin
      req_up    = cnt_up[i] & ~cnt_down[i];
      req_dn    = cnt_down[i] & ~cnt_up[i];
      match     = (req_up & dir_q[i]) | (req_dn & ~dir_q[i]);
      step      = 1'b0;
      step_dir  = dir_q[i];
      nstate[i] = state_q[i];
      ndir[i]   = dir_q[i];
`ifdef JOINT_AUTOREPEAT_EN
      ntimer[i] = timer_q[i];
`endif
      case (state_q[i])
        IDLE: begin
          if (req_up | req_dn) begin
            step      = 1'b1;
            step_dir  = req_up;
            ndir[i]   = req_up;
            nstate[i] = HOLD;
`ifdef JOINT_AUTOREPEAT_EN
            ntimer[i] = '0;
`endif
          end
        end
        HOLD: begin
          if (!match) begin
            nstate[i] = IDLE;
`ifdef JOINT_AUTOREPEAT_EN
          end else if (timer_q[i] == TW'(HOLD_DLY-1)) begin
            step      = 1'b1;
            ntimer[i] = '0;
            nstate[i] = REPEAT;
          end else begin
            ntimer[i] = timer_q[i] + 1'b1;
`endif
          end
        end
`ifdef JOINT_AUTOREPEAT_EN
        REPEAT: begin
          if (!match) begin
            nstate[i] = IDLE;
          end else if (timer_q[i] == TW'(RPT_PER-1)) begin
            step      = 1'b1;
            ntimer[i] = '0;
          end else begin
            ntimer[i] = timer_q[i] + 1'b1;
          end
        end
`endif
        default: nstate[i] = IDLE;
      endcase

      // One extra bit of headroom so +1/-1 never wraps before the limit test.
      ext = {1'b0, pos_q[i]};
      if (step) begin
        if (step_dir && (ext < PMAX))
          ext = ext + 1'b1;
        else if (!step_dir && (ext > PMIN))
          ext = ext - 1'b1;
      end

      if (load && (int'(load_ch) == i)) begin
        lv = {1'b0, load_val};
        if (lv < PMIN)      ext = PMIN;
        else if (lv > PMAX) ext = PMAX;
        else                ext = lv;
        nstate[i] = IDLE;
`ifdef JOINT_AUTOREPEAT_EN
        ntimer[i] = '0;
`endif
      end
      npos[i] = ext[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        pos_q[i]      <= WIDTH'(INIT_POS);
        state_q[i]    <= IDLE;
        dir_q[i]      <= 1'b0;
        step_pulse[i] <= 1'b0;
`ifdef JOINT_AUTOREPEAT_EN
        timer_q[i]    <= '0;
`endif
      end else begin
        pos_q[i]      <= npos[i];
        state_q[i]    <= nstate[i];
        dir_q[i]      <= ndir[i];
        step_pulse[i] <= (npos[i] != pos_q[i]);
`ifdef JOINT_AUTOREPEAT_EN
        timer_q[i]    <= ntimer[i];
`endif
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign pos[g*WIDTH +: WIDTH] = pos_q[g];
    assign at_min[g] = ({1'b0, pos_q[g]} == PMIN);
    assign at_max[g] = ({1'b0, pos_q[g]} == PMAX);
  end

endmodule

// File: tb/tb_joint_pos_counter.sv
// Randomized + directed bench for joint_pos_counter against a press-length reference model.
module tb_joint_pos_counter;

  localparam int PMAX = 200;
  localparam int HD   = 4;
  localparam int RP   = 2;

  logic        clk;
  logic        rst;
  logic [1:0]  cnt_up, cnt_down;
  logic        load;
  logic [0:0]  load_ch;
  logic [7:0]  load_val;
  logic [15:0] pos;
  logic [1:0]  at_min, at_max, step_pulse;

  joint_pos_counter #(
    .WIDTH(8), .NCH(2), .POS_MIN(0), .POS_MAX(PMAX),
    .INIT_POS(0), .HOLD_DLY(HD), .RPT_PER(RP)
  ) dut (
    .clk(clk), .rst(rst), .cnt_up(cnt_up), .cnt_down(cnt_down),
    .load(load), .load_ch(load_ch), .load_val(load_val),
    .pos(pos), .at_min(at_min), .at_max(at_max), .step_pulse(step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int mpos [2];
  int run  [2];   // cycles since the current press began, -1 = no press
  int mdir [2];
  bit mpulse [2];
  int pulses0, pulses1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit scheduled(input int k);
`ifdef JOINT_AUTOREPEAT_EN
    return (k == 0) || (k >= HD && ((k - HD) % RP) == 0);
`else
    return (k == 0);
`endif
  endfunction

  function automatic int sat(input int v);
    if (v > PMAX) return PMAX;
    if (v < 0) return 0;
    return v;
  endfunction

  task automatic model_update();
    int old, r;
    for (int c = 0; c < 2; c++) begin
      old = mpos[c];
      r = (cnt_up[c] && !cnt_down[c]) ? 1 : ((cnt_down[c] && !cnt_up[c]) ? -1 : 0);
      if (rst) begin
        mpos[c] = 0;
        run[c]  = -1;
      end else if (load && (int'(load_ch) == c)) begin
        mpos[c] = sat(int'(load_val));
        run[c]  = -1;
      end else if (run[c] < 0) begin
        if (r != 0) begin
          run[c]  = 0;
          mdir[c] = r;
          mpos[c] = sat(mpos[c] + r);
        end
      end else if (r == mdir[c]) begin
        run[c]++;
        if (scheduled(run[c])) mpos[c] = sat(mpos[c] + r);
      end else begin
        run[c] = -1;
      end
      mpulse[c] = !rst && (mpos[c] != old);
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    chk("pos0", 32'(pos[7:0]), 32'(mpos[0]));
    chk("pos1", 32'(pos[15:8]), 32'(mpos[1]));
    chk("at_min", 32'(at_min), 32'({mpos[1] == 0, mpos[0] == 0}));
    chk("at_max", 32'(at_max), 32'({mpos[1] == PMAX, mpos[0] == PMAX}));
    chk("step_pulse", 32'(step_pulse), 32'({mpulse[1], mpulse[0]}));
    pulses0 += int'(step_pulse[0]);
    pulses1 += int'(step_pulse[1]);
  endtask

  task automatic do_load(input int ch, input int val);
    load = 1'b1; load_ch = 1'(ch); load_val = 8'(val);
    tick();
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    cnt_up = '0; cnt_down = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  int left [2];
  int mode [2];

  initial begin
    rst = 1'b1; cnt_up = '0; cnt_down = '0; load = 1'b0; load_ch = '0; load_val = '0;
    for (int c = 0; c < 2; c++) begin mpos[c] = 0; run[c] = -1; mdir[c] = 0; end
    pulses0 = 0; pulses1 = 0;

    // reset state
    tick(); tick();
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_at_min", 32'(at_min), 32'd3);
    chk("rst_at_max", 32'(at_max), 32'd0);
    chk("rst_pulse", 32'(step_pulse), 32'd0);
    rst = 1'b0;
    idle(1);

    // load then single up press
    do_load(0, 10);
    chk("load10", 32'(pos[7:0]), 32'd10);
    pulses0 = 0;
    cnt_up = 2'b01; tick();
    idle(2);
    chk("press_pos0", 32'(pos[7:0]), 32'd11);
    chk("press_pos1", 32'(pos[15:8]), 32'd0);
    chk("press_pulses", 32'(pulses0), 32'd1);

    // hold 10 cycles from 0
    do_load(0, 0);
    idle(1);
    pulses0 = 0;
    cnt_up = 2'b01;
    for (int i = 0; i < 10; i++) tick();
    idle(1);
`ifdef JOINT_AUTOREPEAT_EN
    chk("hold10_pos", 32'(pos[7:0]), 32'd4);
    chk("hold10_pulses", 32'(pulses0), 32'd4);
`else
    chk("hold10_pos", 32'(pos[7:0]), 32'd1);
    chk("hold10_pulses", 32'(pulses0), 32'd1);
`endif

    // saturate at the top
    do_load(0, 199);
    idle(1);
    pulses0 = 0;
    cnt_up = 2'b01;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_pos", 32'(pos[7:0]), 32'd200);
    chk("sat_at_max", 32'(at_max[0]), 32'd1);
    chk("sat_pulses", 32'(pulses0), 32'd1);
    idle(1);

    // conflicting requests on channel 1, then clamped load
    do_load(1, 77);
    idle(1);
    pulses1 = 0;
    cnt_up = 2'b10; cnt_down = 2'b10;
    for (int i = 0; i < 8; i++) tick();
    chk("both_pos1", 32'(pos[15:8]), 32'd77);
    chk("both_pulses", 32'(pulses1), 32'd0);
    idle(1);
    do_load(1, 250);
    chk("clamp_pos1", 32'(pos[15:8]), 32'd200);

    // reset in the middle of a repeat run
    do_load(0, 50);
    cnt_down = 2'b01;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick(); tick();
    chk("rst_rpt_pos", 32'(pos), 32'd0);
    rst = 1'b0;
    pulses0 = 0;
    tick();
    chk("post_rst_pos0", 32'(pos[7:0]), 32'd0);
    chk("post_rst_pulse", 32'(step_pulse[0]), 32'd0);
    tick(); tick();
    chk("post_rst_pulses", 32'(pulses0), 32'd0);
    idle(2);

    // randomized soak
    left[0] = 0; left[1] = 0; mode[0] = 0; mode[1] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (left[c] == 0) begin
          left[c] = int'($urandom_range(1, 14));
          mode[c] = int'($urandom_range(0, 3));
        end
        left[c]--;
        cnt_up[c]   = (mode[c] == 1) || (mode[c] == 3);
        cnt_down[c] = (mode[c] == 2) || (mode[c] == 3);
      end
      load     = ($urandom_range(0, 29) == 0);
      load_ch  = 1'($urandom_range(0, 1));
      load_val = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255)) : 8'($urandom_range(0, 255));
      rst      = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; load = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/joint_pos_counter.md
JOINT_POS_COUNTER -- requirements
Module: joint_pos_counter

Interface
REQ-001 Parameter WIDTH, default 8: position width per channel in bits.
REQ-002 Parameter NCH, default 4: number of independent joint channels.
REQ-003 Parameter POS_MIN, default 0: lower saturation limit.
REQ-004 Parameter POS_MAX, default 2**WIDTH-1: upper saturation limit.
REQ-005 Parameter INIT_POS, default 0: reset position for every channel.
REQ-006 Parameter HOLD_DLY, default 4: cycles from the first step to the first auto-repeat step.
REQ-007 Parameter RPT_PER, default 2: cycles between auto-repeat steps.
REQ-008 clk  input  1  sole clock, all state updates on its rising edge.
REQ-009 rst  input  1  reset, synchronous, active-high.
REQ-010 cnt_up  input  NCH  per-channel increment request, level, synchronous to clk.
REQ-011 cnt_down  input  NCH  per-channel decrement request, level, synchronous to clk.
REQ-012 load  input  1  one-cycle load strobe.
REQ-013 load_ch  input  clog2(NCH), min 1  channel targeted by load.
REQ-014 load_val  input  WIDTH  value to load.
REQ-015 pos  output  NCH*WIDTH  registered positions, channel i at bits [i*WIDTH +: WIDTH].
REQ-016 at_min / at_max  output  NCH each  high while pos of channel i equals POS_MIN / POS_MAX.
REQ-017 step_pulse  output  NCH  registered; high for one cycle after any cycle in which channel i's pos changed.

Function
REQ-018 Each channel is independent. Its request is +1 if only cnt_up is high, -1 if only cnt_down is high, and none if both or neither are high.
REQ-019 Each channel has an FSM with states IDLE, HOLD and REPEAT, plus a cycle timer.
REQ-020 In IDLE with a request: step once, latch the direction, clear the timer and go to HOLD.
REQ-021 In HOLD or REPEAT, if the request is not equal to the latched direction: go to IDLE with no step that cycle.
REQ-022 In HOLD with a matching request: increment the timer. At timer==HOLD_DLY-1, step, clear the timer and go to REPEAT.
REQ-023 In REPEAT with a matching request: increment the timer. At timer==RPT_PER-1, step and clear the timer.
REQ-024 Resulting step timing for a continuous hold starting at offset 0: steps at offsets 0, HOLD_DLY, HOLD_DLY+RPT_PER, HOLD_DLY+2*RPT_PER, and so on.
REQ-025 A step saturates at POS_MIN or POS_MAX. A step attempted at a limit leaves pos unchanged, keeps the FSM sequencing and produces no step_pulse.
REQ-026 pos updates on the clock edge that samples the triggering condition, so the new value is visible one cycle later.
REQ-027 A direction reversal without an intervening release costs one IDLE cycle; the new direction steps on the following cycle.
REQ-028 load has priority over stepping for channel load_ch. It writes load_val clamped to [POS_MIN, POS_MAX], sends that FSM to IDLE and clears its timer.
REQ-029 load pulses step_pulse only if the loaded value differs from the current pos. Other channels are unaffected by load.
REQ-030 A load_ch value >= NCH is ignored.
REQ-031 Arithmetic uses WIDTH+1 bits internally and never wraps.

Reset
REQ-032 While rst is high: every pos = INIT_POS, every FSM = IDLE, timers = 0, step_pulse = 0. rst overrides load and requests.
REQ-033 At reset, at_min and at_max reflect INIT_POS. Reset during REPEAT aborts the repeat sequence immediately.
REQ-034 On the first cycle after rst deasserts, a held request is treated as a fresh press.

Configuration
REQ-035 Macro JOINT_AUTOREPEAT_EN defined: behaviour as in REQ-022 to REQ-024.
REQ-036 Macro JOINT_AUTOREPEAT_EN undefined: REPEAT and the timer are removed. HOLD waits for the request to end and then goes to IDLE, giving exactly one step per press. HOLD_DLY and RPT_PER are ignored.

Verification
REQ-037 Bench instance is NCH=2, WIDTH=8, HOLD_DLY=4, RPT_PER=2, INIT_POS=0, POS_MAX=200.
REQ-038 rst high for 2 cycles -> pos=0 on both channels, at_min=2'b11, at_max=0, step_pulse=0.
REQ-039 Load 10 to channel 0, then cnt_up[0] high for 1 cycle -> pos0=11, one step_pulse[0], pos1 unchanged.
REQ-040 cnt_up[0] held 10 cycles from pos0=0 -> steps at offsets 0, 4, 6 and 8, final pos0=4. Without the macro, final pos0=1.
REQ-041 pos0=199, cnt_up[0] held 20 cycles -> pos0=200, at_max[0]=1, exactly one step_pulse.
REQ-042 cnt_up[1] and cnt_down[1] both high for 8 cycles -> pos1 unchanged, no pulse. Load_val=250 to channel 1 -> pos1=200.
REQ-043 rst asserted during REPEAT with cnt_down held -> pos=0. After release, first step occurs on the cycle after rst drops (saturated at 0, no pulse).
